// File: rtl/local_memory_arbiter_pkg.sv
// Shared definitions for the local SRAM secondary-port arbiter.
package local_memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_e;

    localparam logic [31:0] READ_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/local_memory_request_mux.sv
// Steers the granted requester onto the memory port and shapes the stall/read-data
// responses returned to both requesters.
module local_memory_request_mux
    import local_memory_arbiter_pkg::*;
#(
    parameter int unsigned ADDRESS_SIZE = 24
) (
    input  state_e                  sel_i,
    input  logic                    timeout_i,
    input  logic [ADDRESS_SIZE-1:0] a_addr_i,
    input  logic [3:0]              a_be_i,
    input  logic                    a_en_i,
    input  logic                    a_we_i,
    input  logic [31:0]             a_wdata_i,
    output logic [31:0]             a_rdata_o,
    output logic                    a_busy_o,
    input  logic [ADDRESS_SIZE-1:0] b_addr_i,
    input  logic [3:0]              b_be_i,
    input  logic                    b_en_i,
    input  logic                    b_we_i,
    input  logic [31:0]             b_wdata_i,
    output logic [31:0]             b_rdata_o,
    output logic                    b_busy_o,
    output logic [ADDRESS_SIZE-1:0] mem_addr_o,
    output logic [3:0]              mem_be_o,
    output logic                    mem_en_o,
    output logic                    mem_we_o,
    output logic [31:0]             mem_wdata_o,
    input  logic [31:0]             mem_rdata_i,
    input  logic                    mem_busy_i
);

    // Non-granted requesters are stalled for as long as they request.
    always_comb begin
        mem_addr_o  = '0;
        mem_be_o    = 4'h0;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_wdata_o = 32'h0;
        a_busy_o    = a_en_i;
        b_busy_o    = b_en_i;
        a_rdata_o   = READ_ONES;
        b_rdata_o   = READ_ONES;
        case (sel_i)
            GRANT_A: begin
                mem_addr_o  = a_addr_i;
                mem_be_o    = a_be_i;
                mem_en_o    = a_en_i;
                mem_we_o    = a_we_i;
                mem_wdata_o = a_wdata_i;
                a_busy_o    = mem_busy_i && !timeout_i;
                a_rdata_o   = timeout_i ? READ_ONES : mem_rdata_i;
            end
            GRANT_B: begin
                mem_addr_o  = b_addr_i;
                mem_be_o    = b_be_i;
                mem_en_o    = b_en_i;
                mem_we_o    = b_we_i;
                mem_wdata_o = b_wdata_i;
                b_busy_o    = mem_busy_i && !timeout_i;
                b_rdata_o   = timeout_i ? READ_ONES : mem_rdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/local_memory_arbiter.sv
// Round-robin arbiter for the local SRAM secondary port with a stall watchdog;
// the grant is held for a whole transaction.
module local_memory_arbiter
    import local_memory_arbiter_pkg::*;
#(
    parameter int unsigned ADDRESS_SIZE   = 24,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned TIMEOUT_WIDTH  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDRESS_SIZE-1:0] aAddress,
    input  logic [3:0]              aByteSelect,
    input  logic                    aEnable,
    input  logic                    aWriteEnable,
    input  logic [31:0]             aDataWrite,
    output logic [31:0]             aDataRead,
    output logic                    aBusy,
    input  logic [ADDRESS_SIZE-1:0] bAddress,
    input  logic [3:0]              bByteSelect,
    input  logic                    bEnable,
    input  logic                    bWriteEnable,
    input  logic [31:0]             bDataWrite,
    output logic [31:0]             bDataRead,
    output logic                    bBusy,
    output logic [ADDRESS_SIZE-1:0] memAddress,
    output logic [3:0]              memByteSelect,
    output logic                    memEnable,
    output logic                    memWriteEnable,
    output logic [31:0]             memDataWrite,
    input  logic [31:0]             memDataRead,
    input  logic                    memBusy,
    output logic                    timeoutError
);

    state_e                   state_q, state_d;
    logic                     last_grant_b_q, last_grant_b_d;
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
    logic                     timeout_q, timeout_d;
    logic                     x_en_c;
    logic                     timeout_hit_c;

    assign x_en_c = (state_q == GRANT_A) ? aEnable :
                    (state_q == GRANT_B) ? bEnable : 1'b0;

    assign timeout_hit_c = x_en_c && memBusy &&
                           (cnt_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

    // Next-state: arbitration in IDLE, completion/abort/watchdog while granted.
    always_comb begin
        state_d        = state_q;
        last_grant_b_d = last_grant_b_q;
        cnt_d          = '0;
        timeout_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (aEnable && (!bEnable || last_grant_b_q)) begin
                    state_d = GRANT_A;
                end else if (bEnable) begin
                    state_d = GRANT_B;
                end
            end
            GRANT_A, GRANT_B: begin
                if (!x_en_c) begin
                    state_d = IDLE;
                end else if (!memBusy) begin
                    state_d        = IDLE;
                    last_grant_b_d = (state_q == GRANT_B);
                end else if (timeout_hit_c) begin
                    state_d        = IDLE;
                    last_grant_b_d = (state_q == GRANT_B);
                    timeout_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            last_grant_b_q <= 1'b1;
            cnt_q          <= '0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_b_q <= last_grant_b_d;
            cnt_q          <= cnt_d;
            timeout_q      <= timeout_d;
        end
    end

    assign timeoutError = timeout_q;

    local_memory_request_mux #(
        .ADDRESS_SIZE(ADDRESS_SIZE)
    ) u_mux (
        .sel_i      (state_q),
        .timeout_i  (timeout_hit_c),
        .a_addr_i   (aAddress),
        .a_be_i     (aByteSelect),
        .a_en_i     (aEnable),
        .a_we_i     (aWriteEnable),
        .a_wdata_i  (aDataWrite),
        .a_rdata_o  (aDataRead),
        .a_busy_o   (aBusy),
        .b_addr_i   (bAddress),
        .b_be_i     (bByteSelect),
        .b_en_i     (bEnable),
        .b_we_i     (bWriteEnable),
        .b_wdata_i  (bDataWrite),
        .b_rdata_o  (bDataRead),
        .b_busy_o   (bBusy),
        .mem_addr_o (memAddress),
        .mem_be_o   (memByteSelect),
        .mem_en_o   (memEnable),
        .mem_we_o   (memWriteEnable),
        .mem_wdata_o(memDataWrite),
        .mem_rdata_i(memDataRead),
        .mem_busy_i (memBusy)
    );

endmodule

// File: tb/tb_local_memory_arbiter.sv
// Bench for local_memory_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_local_memory_arbiter;

    localparam int unsigned AW = 24;
    localparam int unsigned TO = 16;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] aAddress, bAddress, memAddress;
    logic [3:0]    aByteSelect, bByteSelect, memByteSelect;
    logic          aEnable, bEnable, memEnable;
    logic          aWriteEnable, bWriteEnable, memWriteEnable;
    logic [31:0]   aDataWrite, bDataWrite, memDataWrite;
    logic [31:0]   aDataRead, bDataRead, memDataRead;
    logic          aBusy, bBusy, memBusy, timeoutError;

    local_memory_arbiter #(.ADDRESS_SIZE(AW), .TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .aAddress(aAddress), .aByteSelect(aByteSelect), .aEnable(aEnable),
        .aWriteEnable(aWriteEnable), .aDataWrite(aDataWrite), .aDataRead(aDataRead), .aBusy(aBusy),
        .bAddress(bAddress), .bByteSelect(bByteSelect), .bEnable(bEnable),
        .bWriteEnable(bWriteEnable), .bDataWrite(bDataWrite), .bDataRead(bDataRead), .bBusy(bBusy),
        .memAddress(memAddress), .memByteSelect(memByteSelect), .memEnable(memEnable),
        .memWriteEnable(memWriteEnable), .memDataWrite(memDataWrite),
        .memDataRead(memDataRead), .memBusy(memBusy), .timeoutError(timeoutError)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Transaction-level model: who owns the port, who was served last, how long
    // the current owner has been stalled, and whether an abort pulse is due.
    int owner;       // 0 none, 1 A, 2 B
    bit served_b;    // last completed/aborted-by-watchdog owner was B
    int stalled;
    bit err_due;
    bit model_ok = 1'b0;

    // Expected outputs for the current cycle
    logic [AW+4+1+1+32-1:0] e_mem;
    logic        e_abusy, e_bbusy, e_err;
    logic [31:0] e_ard, e_brd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Let combinational outputs settle, derive expectations, compare.
    task automatic settle();
        bit lim;
        #2;
        e_mem   = '0;
        e_abusy = aEnable;
        e_bbusy = bEnable;
        e_ard   = ONES;
        e_brd   = ONES;
        e_err   = err_due;
        if (owner == 1) begin
            e_mem   = {aAddress, aByteSelect, aEnable, aWriteEnable, aDataWrite};
            lim     = aEnable && memBusy && (stalled == TO - 1);
            e_abusy = memBusy && !lim;
            e_ard   = lim ? ONES : memDataRead;
        end else if (owner == 2) begin
            e_mem   = {bAddress, bByteSelect, bEnable, bWriteEnable, bDataWrite};
            lim     = bEnable && memBusy && (stalled == TO - 1);
            e_bbusy = memBusy && !lim;
            e_brd   = lim ? ONES : memDataRead;
        end
        if (model_ok) begin
            chk("mem_bundle", 64'({memAddress, memByteSelect, memEnable, memWriteEnable, memDataWrite} ^ e_mem), 64'd0);
            chk("aBusy", 64'(aBusy), 64'(e_abusy));
            chk("bBusy", 64'(bBusy), 64'(e_bbusy));
            chk("aDataRead", 64'(aDataRead), 64'(e_ard));
            chk("bDataRead", 64'(bDataRead), 64'(e_brd));
            chk("timeoutError", 64'(timeoutError), 64'(e_err));
        end
    endtask

    // Advance the model across the clock edge using the inputs now applied.
    task automatic adv();
        bit xen;
        if (rst) begin
            owner = 0; served_b = 1'b1; stalled = 0; err_due = 1'b0; model_ok = 1'b1;
        end else begin
            err_due = 1'b0;
            if (owner == 0) begin
                stalled = 0;
                if (aEnable && (!bEnable || served_b)) owner = 1;
                else if (bEnable) owner = 2;
            end else begin
                xen = (owner == 1) ? aEnable : bEnable;
                if (!xen) begin
                    owner = 0; stalled = 0;
                end else if (!memBusy) begin
                    served_b = (owner == 2); owner = 0; stalled = 0;
                end else if (stalled + 1 >= TO) begin
                    served_b = (owner == 2); owner = 0; stalled = 0; err_due = 1'b1;
                end else begin
                    stalled++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        aAddress = '0; aByteSelect = 4'h0; aEnable = 1'b0; aWriteEnable = 1'b0; aDataWrite = 32'h0;
        bAddress = '0; bByteSelect = 4'h0; bEnable = 1'b0; bWriteEnable = 1'b0; bDataWrite = 32'h0;
        memDataRead = 32'h0; memBusy = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        settle(); adv();
        settle(); adv();
        rst = 1'b0;
    endtask

    int burst;
    bit a_done, b_done;

    initial begin
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        do_reset();
        chk("reset_memEnable", 64'(memEnable), 64'd0);
        chk("reset_aDataRead", 64'(aDataRead), 64'(ONES));

        // 1: single A write
        aEnable = 1'b1; aWriteEnable = 1'b1; aAddress = 24'h000010; aByteSelect = 4'hF;
        aDataWrite = 32'hDEADBEEF;
        settle(); chk("t1_c1_aBusy", 64'(aBusy), 64'd1); chk("t1_c1_memEn", 64'(memEnable), 64'd0); adv();
        settle();
        chk("t1_c2_memEn", 64'(memEnable), 64'd1);
        chk("t1_c2_memWe", 64'(memWriteEnable), 64'd1);
        chk("t1_c2_memWd", 64'(memDataWrite), 64'hDEADBEEF);
        chk("t1_c2_memAddr", 64'(memAddress), 64'h10);
        chk("t1_c2_aBusy", 64'(aBusy), 64'd0);
        adv();
        clear_inputs();
        settle(); chk("t1_c3_memEn", 64'(memEnable), 64'd0); adv();

        // 2: simultaneous requests alternate
        do_reset();
        aEnable = 1'b1; aAddress = 24'h000100; bEnable = 1'b1; bAddress = 24'h000200;
        settle(); chk("t2_idle_memEn", 64'(memEnable), 64'd0); adv();
        settle(); chk("t2_first_A", 64'(memAddress), 64'h100); chk("t2_bBusy", 64'(bBusy), 64'd1); adv();
        aEnable = 1'b0;
        settle(); adv();
        settle(); chk("t2_then_B", 64'(memAddress), 64'h200); chk("t2_bBusy0", 64'(bBusy), 64'd0); adv();
        bEnable = 1'b0;
        settle(); adv();
        aEnable = 1'b1; bEnable = 1'b1;
        settle(); adv();
        settle(); chk("t2_again_A", 64'(memAddress), 64'h100); adv();
        aEnable = 1'b0;
        settle(); adv();
        settle(); adv();
        clear_inputs();
        settle(); adv();

        // 3: B read with one stall cycle
        bEnable = 1'b1; bAddress = 24'h000020; bByteSelect = 4'hF;
        settle(); chk("t3_idle_aRd", 64'(aDataRead), 64'(ONES)); adv();
        memBusy = 1'b1;
        settle(); chk("t3_stall_bBusy", 64'(bBusy), 64'd1); chk("t3_stall_aRd", 64'(aDataRead), 64'(ONES)); adv();
        memBusy = 1'b0; memDataRead = 32'h12345678;
        settle();
        chk("t3_bRd", 64'(bDataRead), 64'h12345678);
        chk("t3_bBusy0", 64'(bBusy), 64'd0);
        chk("t3_done_aRd", 64'(aDataRead), 64'(ONES));
        adv();
        clear_inputs();
        settle(); adv();

        // 4: watchdog abort of A with B pending
        aEnable = 1'b1; aAddress = 24'h000030; memBusy = 1'b1; memDataRead = 32'hCAFEF00D;
        settle(); adv();
        bEnable = 1'b1; bAddress = 24'h000040;
        for (int g = 1; g <= 16; g++) begin
            settle();
            if (g < 16) chk("t4_aBusy_held", 64'(aBusy), 64'd1);
            else begin
                chk("t4_aBusy_drop", 64'(aBusy), 64'd0);
                chk("t4_aRd_ones", 64'(aDataRead), 64'(ONES));
            end
            chk("t4_no_err_yet", 64'(timeoutError), 64'd0);
            adv();
        end
        aEnable = 1'b0;
        settle(); chk("t4_err_pulse", 64'(timeoutError), 64'd1); chk("t4_idle", 64'(memEnable), 64'd0); adv();
        settle(); chk("t4_err_once", 64'(timeoutError), 64'd0); chk("t4_B_next", 64'(memAddress), 64'h40); adv();
        settle(); adv();
        memBusy = 1'b0;
        settle(); chk("t4_B_done", 64'(bBusy), 64'd0); adv();
        clear_inputs();
        settle(); adv();

        // 5: A withdraws mid-grant; priority unchanged
        aEnable = 1'b1; aAddress = 24'h000050; memBusy = 1'b1;
        settle(); adv();
        settle(); chk("t5_grantA", 64'(memEnable), 64'd1); adv();
        aEnable = 1'b0;
        settle(); adv();
        settle(); chk("t5_idle", 64'(memEnable), 64'd0); chk("t5_no_err", 64'(timeoutError), 64'd0); adv();
        aEnable = 1'b1; bEnable = 1'b1; bAddress = 24'h000058; memBusy = 1'b0;
        settle(); adv();
        settle(); chk("t5_tie_A", 64'(memAddress), 64'h50); adv();
        aEnable = 1'b0;
        settle(); adv();
        settle(); adv();
        clear_inputs();
        settle(); adv();

        // 6: reset during GRANT_B
        bEnable = 1'b1; bAddress = 24'h000060; memBusy = 1'b1;
        settle(); adv();
        settle(); chk("t6_grantB", 64'(memEnable), 64'd1); adv();
        rst = 1'b1;
        settle(); adv();
        rst = 1'b0; aEnable = 1'b1; aAddress = 24'h000070;
        settle();
        chk("t6_memEn", 64'(memEnable), 64'd0);
        chk("t6_bRd", 64'(bDataRead), 64'(ONES));
        chk("t6_no_err", 64'(timeoutError), 64'd0);
        adv();
        settle(); chk("t6_tie_A", 64'(memAddress), 64'h70); adv();
        clear_inputs();
        do_reset();

        // Randomized traffic obeying the hold-until-done protocol
        burst = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            settle();
            a_done = aEnable && !e_abusy;
            b_done = bEnable && !e_bbusy;
            adv();
            rst = ($urandom_range(0, 199) == 0);
            if (aEnable && !a_done) begin
                if ($urandom_range(0, 39) == 0) aEnable = 1'b0;
            end else if ($urandom_range(0, 1) == 0) begin
                aEnable = 1'b1; aAddress = AW'($urandom); aByteSelect = 4'($urandom);
                aWriteEnable = 1'($urandom); aDataWrite = $urandom;
            end else aEnable = 1'b0;
            if (bEnable && !b_done) begin
                if ($urandom_range(0, 39) == 0) bEnable = 1'b0;
            end else if ($urandom_range(0, 1) == 0) begin
                bEnable = 1'b1; bAddress = AW'($urandom); bByteSelect = 4'($urandom);
                bWriteEnable = 1'($urandom); bDataWrite = $urandom;
            end else bEnable = 1'b0;
            if (burst > 0) burst--;
            else if ($urandom_range(0, 59) == 0) burst = 22;
            memBusy = (burst > 0) || ($urandom_range(0, 9) < 4);
            memDataRead = $urandom;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
